// File: rtl/round_key_store_if.sv
// Key-load / round-key read bus between the decryption controller and round_key_store.
// The controller is the master; the key store is the slave.
interface round_key_store_if;
  logic         key_load;
  logic [127:0] cipher_key;
  logic [3:0]   rk_index;
  logic         busy;
  logic         key_ready;
  logic [127:0] round_key;
  logic         rk_valid;

  modport master (
    output key_load, cipher_key, rk_index,
    input  busy, key_ready, round_key, rk_valid
  );

  modport slave (
    input  key_load, cipher_key, rk_index,
    output busy, key_ready, round_key, rk_valid
  );
endinterface

// File: rtl/round_key_store.sv
// Iterative AES-128 key expansion (one round key per clock) into an 11-entry
// round-key memory, with a registered one-cycle-latency read port.

module s_box (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_x2, w_x3, w_x6, w_x12, w_x15, w_x30, w_x60, w_x120, w_x240, w_x252, w_inv;

  // Multiplicative inverse as x^254 in GF(2^8); zero maps to zero naturally.
  assign w_x2   = gfMul(i_byte, i_byte);
  assign w_x3   = gfMul(w_x2, i_byte);
  assign w_x6   = gfMul(w_x3, w_x3);
  assign w_x12  = gfMul(w_x6, w_x6);
  assign w_x15  = gfMul(w_x12, w_x3);
  assign w_x30  = gfMul(w_x15, w_x15);
  assign w_x60  = gfMul(w_x30, w_x30);
  assign w_x120 = gfMul(w_x60, w_x60);
  assign w_x240 = gfMul(w_x120, w_x120);
  assign w_x252 = gfMul(w_x240, w_x12);
  assign w_inv  = gfMul(w_x252, w_x2);

  assign o_byte = w_inv
                ^ {w_inv[6:0], w_inv[7]}
                ^ {w_inv[5:0], w_inv[7:6]}
                ^ {w_inv[4:0], w_inv[7:5]}
                ^ {w_inv[3:0], w_inv[7:4]}
                ^ 8'h63;
endmodule

module round_key_store (
  input  logic             clk,
  input  logic             n_rst,
  round_key_store_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t       r_state;
  logic [3:0]   r_rnd;
  logic [127:0] r_slot [0:10];
  logic [127:0] r_roundKey;
  logic         r_rkValid;

  logic [3:0]   w_prevIdx;
  logic [127:0] w_prevKey;
  logic [31:0]  w_rotWord;
  logic [31:0]  w_subWord;
  logic [7:0]   w_rcon;
  logic [31:0]  w_temp;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_nextKey;
  logic [127:0] w_readKey;
  logic         w_readOk;

  assign w_prevIdx = r_rnd - 4'd1;

  always_comb begin
    w_prevKey = '0;
    w_readKey = '0;
    for (int k = 0; k < 11; k++) begin
      if (w_prevIdx == k[3:0])    w_prevKey = r_slot[k];
      if (bus.rk_index == k[3:0]) w_readKey = r_slot[k];
    end
  end

  assign w_rotWord = {w_prevKey[23:0], w_prevKey[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gSbox
      s_box uSbox (
        .i_byte (w_rotWord[8*g +: 8]),
        .o_byte (w_subWord[8*g +: 8])
      );
    end
  endgenerate

  always_comb begin
    case (r_rnd)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_temp    = w_subWord ^ {w_rcon, 24'h000000};
  assign w_n0      = w_prevKey[127:96] ^ w_temp;
  assign w_n1      = w_prevKey[95:64]  ^ w_n0;
  assign w_n2      = w_prevKey[63:32]  ^ w_n1;
  assign w_n3      = w_prevKey[31:0]   ^ w_n2;
  assign w_nextKey = {w_n0, w_n1, w_n2, w_n3};

  assign w_readOk = (r_state == READY) && (bus.rk_index <= 4'd10);

  // A load in READY still lets the same-cycle read see the old slot contents.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_rnd      <= 4'd0;
      r_roundKey <= '0;
      r_rkValid  <= 1'b0;
      for (int k = 0; k < 11; k++) r_slot[k] <= '0;
    end else begin
      r_rkValid  <= w_readOk;
      r_roundKey <= w_readOk ? w_readKey : '0;
      case (r_state)
        IDLE, READY: begin
          if (bus.key_load) begin
            r_slot[0] <= bus.cipher_key;
            r_rnd     <= 4'd1;
            r_state   <= EXPAND;
          end
        end
        EXPAND: begin
          for (int k = 1; k < 11; k++) begin
            if (r_rnd == k[3:0]) r_slot[k] <= w_nextKey;
          end
          if (r_rnd == 4'd10) begin
            r_rnd   <= 4'd0;
            r_state <= READY;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        default: begin
          r_rnd   <= 4'd0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state == EXPAND);
  assign bus.key_ready = (r_state == READY);
  assign bus.round_key = r_roundKey;
  assign bus.rk_valid  = r_rkValid;
endmodule

// File: tb/tb_round_key_store.sv
// Randomized self-checking bench for round_key_store against a word-level
// FIPS-197 key-schedule model built from a brute-force S-box table.
module tb_round_key_store;
  logic clk = 1'b0;
  logic n_rst = 1'b1;

  always #5 clk = ~clk;

  round_key_store_if bus ();

  round_key_store dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  int compareCount = 0;
  int failCount    = 0;

  logic [7:0]   refSbox   [256];
  logic [127:0] modelKeys [11];

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Table built by exhaustive inverse search plus the bitwise affine map.
  task automatic buildSbox();
    logic [7:0] inv;
    logic [7:0] c;
    logic [7:0] s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gfMul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
             ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
      end
      refSbox[x] = s;
    end
  endtask

  task automatic computeModel(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {refSbox[temp[31:24]], refSbox[temp[23:16]], refSbox[temp[15:8]], refSbox[temp[7:0]]};
        temp = temp ^ {rc, 24'h000000};
        rc   = gfMul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) modelKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic [127:0] key, input logic [3:0] idx);
    bus.key_load   = load;
    bus.cipher_key = key;
    bus.rk_index   = idx;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleRead(input string tag);
    checkOutput({tag, "_key"},   bus.round_key, '0);
    checkOutput({tag, "_valid"}, {127'd0, bus.rk_valid}, '0);
  endtask

  // Load at E0, then confirm busy for exactly E0..E9 and key_ready after E10.
  task automatic loadAndWait(input logic [127:0] key, input string tag);
    applyStimulus(1'b1, key, 4'd0);
    for (int c = 1; c <= 10; c++) begin
      checkOutput({tag, "_busy"},  {127'd0, bus.busy},      128'd1);
      checkOutput({tag, "_ready"}, {127'd0, bus.key_ready}, 128'd0);
      applyStimulus(1'b0, '0, 4'd0);
    end
    checkOutput({tag, "_busyDone"},  {127'd0, bus.busy},      128'd0);
    checkOutput({tag, "_readyDone"}, {127'd0, bus.key_ready}, 128'd1);
  endtask

  task automatic readAll(input string tag);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, '0, k[3:0]);
      checkOutput({tag, "_key"},   bus.round_key, modelKeys[k]);
      checkOutput({tag, "_valid"}, {127'd0, bus.rk_valid}, 128'd1);
    end
  endtask

  logic [127:0] keyB;
  logic [127:0] keyC;
  logic [3:0]   idx;
  logic [127:0] expKey;

  initial begin
    bus.key_load   = 1'b0;
    bus.cipher_key = '0;
    bus.rk_index   = 4'd0;
    buildSbox();

    // Reset asserted mid-cycle, then idle reads.
    @(posedge clk);
    #3 n_rst = 1'b0;
    #1;
    checkOutput("rst_busy",  {127'd0, bus.busy},      '0);
    checkOutput("rst_ready", {127'd0, bus.key_ready}, '0);
    checkIdleRead("rst_read");
    #3 n_rst = 1'b1;
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, '0, 4'd0);
    checkOutput("idle_busy",  {127'd0, bus.busy},      '0);
    checkOutput("idle_ready", {127'd0, bus.key_ready}, '0);
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, '0, k[3:0]);
      checkIdleRead("idle_read");
    end

    // FIPS-197 expansion and the known round keys.
    computeModel(FIPS_KEY);
    loadAndWait(FIPS_KEY, "fips");
    applyStimulus(1'b0, '0, 4'd0);
    checkOutput("fips_rk0", bus.round_key, FIPS_KEY);
    checkOutput("fips_rk0_valid", {127'd0, bus.rk_valid}, 128'd1);
    applyStimulus(1'b0, '0, 4'd1);
    checkOutput("fips_rk1", bus.round_key, FIPS_RK1);
    applyStimulus(1'b0, '0, 4'd10);
    checkOutput("fips_rk10", bus.round_key, FIPS_RK10);
    checkOutput("fips_rk10_valid", {127'd0, bus.rk_valid}, 128'd1);

    // Reverse walk at full throughput.
    for (int k = 10; k >= 0; k--) begin
      applyStimulus(1'b0, '0, k[3:0]);
      checkOutput("walk_key",   bus.round_key, modelKeys[k]);
      checkOutput("walk_valid", {127'd0, bus.rk_valid}, 128'd1);
    end

    // Out-of-range reads, then a good read.
    applyStimulus(1'b0, '0, 4'd11);
    checkIdleRead("oor11");
    applyStimulus(1'b0, '0, 4'd15);
    checkIdleRead("oor15");
    applyStimulus(1'b0, '0, 4'd10);
    checkOutput("oor_recover", bus.round_key, FIPS_RK10);

    // Random read mix including out-of-range indices.
    for (int n = 0; n < 24; n++) begin
      idx = 4'($urandom_range(0, 15));
      applyStimulus(1'b0, '0, idx);
      expKey = (idx <= 4'd10) ? modelKeys[idx] : '0;
      checkOutput("rand_key",   bus.round_key, expKey);
      checkOutput("rand_valid", {127'd0, bus.rk_valid}, {127'd0, (idx <= 4'd10)});
    end

    // Reload from READY with a same-cycle read, then a second load mid-expansion.
    keyB = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, keyB, 4'd3);
    checkOutput("coll_oldRead",  bus.round_key, modelKeys[3]);
    checkOutput("coll_oldValid", {127'd0, bus.rk_valid}, 128'd1);
    for (int c = 1; c <= 10; c++) begin
      checkOutput("coll_busy",  {127'd0, bus.busy},      128'd1);
      checkOutput("coll_ready", {127'd0, bus.key_ready}, 128'd0);
      if (c > 1) checkIdleRead("coll_expRead");
      applyStimulus(c == 4, SEQ_KEY, 4'($urandom_range(0, 10)));
    end
    checkOutput("coll_readyDone", {127'd0, bus.key_ready}, 128'd1);
    checkIdleRead("coll_lastExpRead");
    computeModel(keyB);
    readAll("coll_final");

    // Reload of the sequential key from READY.
    computeModel(SEQ_KEY);
    loadAndWait(SEQ_KEY, "seq");
    applyStimulus(1'b0, '0, 4'd10);
    checkOutput("seq_rk10", bus.round_key, SEQ_RK10);
    readAll("seq_all");

    // Reset in the middle of an expansion, then a fresh full load.
    keyC = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, keyC, 4'd0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b0, '0, 4'd0);
    checkOutput("mid_busyBefore", {127'd0, bus.busy}, 128'd1);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("mid_busy",  {127'd0, bus.busy},      '0);
    checkOutput("mid_ready", {127'd0, bus.key_ready}, '0);
    checkIdleRead("mid_read");
    #3 n_rst = 1'b1;
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b0, '0, k[3:0]);
      checkIdleRead("mid_idleRead");
    end
    computeModel(keyC);
    loadAndWait(keyC, "fresh");
    for (int k = 10; k >= 0; k--) begin
      applyStimulus(1'b0, '0, k[3:0]);
      checkOutput("fresh_key",   bus.round_key, modelKeys[k]);
      checkOutput("fresh_valid", {127'd0, bus.rk_valid}, 128'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
